pool_flatten_buffer: RTL

- Downstream neighbour of the 4-lane pool/ReLU stage.
- Collects one full pooled feature map per channel: (W/2)x(W/2) signed words per lane, arriving with independent per-lane valids and no backpressure.
- Once all four lanes are complete, streams the flattened vector out one word per cycle, channel-major, over a valid/ready handshake to the fully-connected stage.

---
 rtl/pool_flatten_buffer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/pool_flatten_buffer.sv
// Collects one pooled feature map per lane (4 lanes x (W/2)^2 words), then streams it channel-major.
// Optional POOL_FLATTEN_DBUF_EN: ping/pong bank sets so the next frame fills while the current one drains.
module pool_flatten_buffer #(
    parameter  int unsigned In_d_W = 32,
    parameter  int unsigned W      = 26,
    localparam int unsigned P      = (W / 2) * (W / 2),
    localparam int unsigned IDX_W  = $clog2(4 * P)
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [3:0]               in_valid,
    input  logic [4*In_d_W-1:0]      in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [In_d_W-1:0] out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last,
    output logic                     frame_done,
    output logic                     err_overflow
);

    localparam int unsigned LANES = 4;
    localparam int unsigned WP_W  = $clog2(P + 1);
`ifdef POOL_FLATTEN_DBUF_EN
    localparam int unsigned NSET  = 2;
`else
    localparam int unsigned NSET  = 1;
`endif
    localparam int unsigned DEPTH = NSET * LANES * P;
    localparam int unsigned BA_W  = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES * P - 1);

    typedef enum logic {FILL, DRAIN} state_t;

    state_t            state;
    logic [WP_W-1:0]   wp [LANES];
    logic [IDX_W-1:0]  rd_idx;
    logic [In_d_W-1:0] bank [DEPTH];

    logic [LANES-1:0]  we;
    logic [LANES-1:0]  drop;
    logic [LANES-1:0]  full;
    logic [BA_W-1:0]   waddr [LANES];
    logic [BA_W-1:0]   raddr;
    logic [BA_W-1:0]   fill_base;
    logic [BA_W-1:0]   drain_base;
    logic              all_full;
    logic              advance;

`ifdef POOL_FLATTEN_DBUF_EN
    logic              fill_set;
    logic              drain_set;
`endif

    // Write enables, drop detection and flat bank addressing (rd_idx is already lane*P + addr).
    always_comb begin
`ifdef POOL_FLATTEN_DBUF_EN
        fill_base  = fill_set  ? BA_W'(LANES * P) : '0;
        drain_base = drain_set ? BA_W'(LANES * P) : '0;
`else
        fill_base  = '0;
        drain_base = '0;
`endif
        for (int c = 0; c < LANES; c++) begin
            full[c]  = (wp[c] == WP_W'(P));
`ifdef POOL_FLATTEN_DBUF_EN
            we[c]    = in_valid[c] && !full[c];
`else
            we[c]    = in_valid[c] && !full[c] && (state == FILL);
`endif
            drop[c]  = in_valid[c] && !we[c];
            waddr[c] = fill_base + BA_W'(c * P) + BA_W'(wp[c]);
        end
        all_full = &full;
        raddr    = drain_base + BA_W'(rd_idx);
        advance  = (state == DRAIN) && (!out_valid || out_ready);
    end

    // Bank storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        for (int c = 0; c < LANES; c++) begin
            if (we[c]) begin
                bank[waddr[c]] <= in_data[c*In_d_W +: In_d_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state        <= FILL;
            for (int c = 0; c < LANES; c++) wp[c] <= '0;
            rd_idx       <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_last     <= 1'b0;
            frame_done   <= 1'b0;
            err_overflow <= 1'b0;
`ifdef POOL_FLATTEN_DBUF_EN
            fill_set     <= 1'b0;
            drain_set    <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            for (int c = 0; c < LANES; c++) begin
                if (we[c]) wp[c] <= wp[c] + WP_W'(1);
            end
            if (|drop) err_overflow <= 1'b1;

            case (state)
                FILL: begin
                    if (all_full) begin
                        state  <= DRAIN;
                        rd_idx <= '0;
`ifdef POOL_FLATTEN_DBUF_EN
                        drain_set <= fill_set;
                        fill_set  <= ~fill_set;
                        for (int c = 0; c < LANES; c++) wp[c] <= '0;
`endif
                    end
                end
                DRAIN: begin
                    if (advance) begin
                        if (out_valid && out_last) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= FILL;
`ifndef POOL_FLATTEN_DBUF_EN
                            for (int c = 0; c < LANES; c++) wp[c] <= '0;
`endif
                        end else begin
                            // Present the next word; held until the consumer takes it.
                            out_valid <= 1'b1;
                            out_data  <= bank[raddr];
                            out_idx   <= rd_idx;
                            out_last  <= (rd_idx == LAST_IDX);
                            rd_idx    <= rd_idx + IDX_W'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
